// File: rtl/mul_hilo_unit_pkg.sv
// Shared types and constants for the HI/LO multiply unit.
package mul_hilo_unit_pkg;

  localparam int W_DEF     = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {MS_IDLE, MS_RUN, MS_FIX} mul_state;

  localparam logic [1:0] MC_NONE = 2'b00;
  localparam logic [1:0] MC_HI   = 2'b01;
  localparam logic [1:0] MC_LO   = 2'b10;

  localparam logic [1:0] AM_MUL  = 2'b01;

  // True when the move select requests a read of HI or LO.
  function automatic logic is_move(input logic [1:0] mc);
    return (mc == MC_HI) || (mc == MC_LO);
  endfunction

endpackage

// File: rtl/mul_hilo_unit_if.sv
// Issue/read bundle between the execute-stage control and the HI/LO multiply unit.
interface mul_hilo_unit_if #(
  parameter int W = 32
);

  logic         start;
  logic         is_signed;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [1:0]   mc;
  logic [W-1:0] hilo_out;
  logic         busy;
  logic         stall;
  logic         done;

  modport master (
    output start, is_signed, src_a, src_b, mc,
    input  hilo_out, busy, stall, done
  );

  modport slave (
    input  start, is_signed, src_a, src_b, mc,
    output hilo_out, busy, stall, done
  );

endinterface

// File: rtl/mul_hilo_unit_shift_add.sv
// Shift-add datapath for the iterative multiplier: holds the magnitude
// operands and the 2W-bit partial product, one multiplier bit per step.
module mul_shift_add
  import mul_hilo_unit_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [CNT_W-1:0] extra_shift,
  input  logic [W-1:0]     mcand_in,
  input  logic [W-1:0]     mplr_in,
  output logic             tail_zero,
  output logic [2*W-1:0]   prod
);

  logic [W-1:0] mcand;
  logic [W-1:0] mplr;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W:0]   sum;

  // Conditional add of the multiplicand into the upper half, carry kept in bit W.
  always_comb begin
    sum = {1'b0, hi};
    if (mplr[0]) begin
      sum = {1'b0, hi} + {1'b0, mcand};
    end
  end

  // Bits above the one consumed this step; all zero means nothing more to add.
  assign tail_zero = ~|mplr[W-1:1];
  assign prod      = {hi, lo};

  // Load operands on issue, then add-and-shift once per step; extra_shift
  // collapses the remaining add-free iterations into the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      mplr  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (load) begin
      mcand <= mcand_in;
      mplr  <= mplr_in;
      hi    <= '0;
      lo    <= '0;
    end else if (step) begin
      mplr     <= mplr >> 1;
      {hi, lo} <= {sum[W:1], sum[0], lo[W-1:1]} >> extra_shift;
    end
  end

endmodule

// File: rtl/mul_hilo_unit.sv
// Iterative 32x32 MULT/MULTU unit with HI/LO registers, MFHI/MFLO read
// port and pipeline stall. Optional build macro MUL_EARLY_EXIT_EN ends the
// iteration as soon as the remaining multiplier bits are all zero.
module mul_hilo_unit
  import mul_hilo_unit_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  mul_hilo_unit_if.slave  bus
);

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  mul_state         state;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic [W-1:0]     hi_reg;
  logic [W-1:0]     lo_reg;
  logic             busy_q;
  logic             done_q;

  logic [W-1:0]     a_abs;
  logic [W-1:0]     b_abs;
  logic             load;
  logic             step;
  logic             tail_zero;
  logic             last_iter;
  logic             exit_now;
  logic [CNT_W-1:0] extra_shift;
  logic [2*W-1:0]   prod;
  logic [2*W-1:0]   fixed;

  // Magnitudes are W-bit unsigned, so the most negative value maps to itself.
  assign a_abs = (bus.is_signed && bus.src_a[W-1]) ? (~bus.src_a + 1'b1) : bus.src_a;
  assign b_abs = (bus.is_signed && bus.src_b[W-1]) ? (~bus.src_b + 1'b1) : bus.src_b;

  assign load        = (state == MS_IDLE) && bus.start;
  assign step        = (state == MS_RUN);
  assign last_iter   = (cnt == CNT_W'(W - 1));
  assign exit_now    = last_iter || (EARLY_EXIT && tail_zero);
  assign extra_shift = (EARLY_EXIT && exit_now) ? (CNT_W'(W - 1) - cnt) : '0;
  assign fixed       = neg ? (~prod + 1'b1) : prod;

  mul_shift_add #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_shift_add (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .extra_shift (extra_shift),
    .mcand_in    (a_abs),
    .mplr_in     (b_abs),
    .tail_zero   (tail_zero),
    .prod        (prod)
  );

  // Sequencing FSM: accept an issue in IDLE, iterate in RUN, sign-fix and commit HI/LO in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MS_IDLE;
      cnt    <= '0;
      neg    <= 1'b0;
      hi_reg <= '0;
      lo_reg <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MS_IDLE: begin
          if (bus.start) begin
            neg    <= bus.is_signed & (bus.src_a[W-1] ^ bus.src_b[W-1]);
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= MS_RUN;
          end
        end
        MS_RUN: begin
          cnt <= cnt + 1'b1;
          if (exit_now) begin
            state <= MS_FIX;
          end
        end
        MS_FIX: begin
          {hi_reg, lo_reg} <= fixed;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= MS_IDLE;
        end
        default: begin
          state  <= MS_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // MFHI/MFLO read mux straight off the committed registers.
  always_comb begin
    bus.hilo_out = '0;
    if (bus.mc == MC_HI) begin
      bus.hilo_out = hi_reg;
    end else if (bus.mc == MC_LO) begin
      bus.hilo_out = lo_reg;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q && (bus.start || is_move(bus.mc));

endmodule
